// File: rtl/start_stop_seq_arbiter.sv
// Round-robin arbiter sharing one start/b/a/stop strobe sequencer
// between NREQ requesters; all outputs registered.
module start_stop_seq_arbiter #(
  parameter int NREQ     = 4,
  parameter int A_DLY    = 1,
  parameter int STOP_GAP = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             start,
  output logic             b,
  output logic             a,
  output logic             stop,
  output logic             busy,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(STOP_GAP + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  if (A_DLY > STOP_GAP || A_DLY < 1 ||
      STOP_GAP < 1 || NREQ < 2) begin : g_bad_cfg
    $error("start_stop_seq_arbiter: illegal parameters");
  end

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             start_q, start_d;
  logic             b_q, b_d;
  logic             a_q, a_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  int               ji;

  // first requester at or after the RR pointer, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    ji       = 0;
    for (int k = 0; k < NREQ; k++) begin
      ji = int'(ptr_q) + k;
      if (ji >= NREQ) ji = ji - NREQ;
      if (!pick_vld && req[PW'(ji)]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(ji);
      end
    end
  end

  // sequencer: strobe values are computed one cycle ahead
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    txn_d   = txn_q;
    done_d  = '0;
    start_d = 1'b0;
    b_d     = 1'b0;
    a_d     = 1'b0;
    stop_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_START;
          idx_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        state_d = S_RUN;
        cnt_d   = '0;
        b_d     = 1'b1;
      end
      S_RUN: begin
        if (cnt_q == CW'(STOP_GAP)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          gnt_d   = '0;
          busy_d  = 1'b0;
          txn_d   = txn_q + 1'b1;
          ptr_d   = (idx_q == PW'(NREQ - 1)) ?
                    '0 : idx_q + PW'(1);
        end else begin
          cnt_d  = cnt_q + 1'b1;
          a_d    = (int'(cnt_q) + 1 == A_DLY);
          stop_d = (int'(cnt_q) + 1 == STOP_GAP);
          done_d = stop_d ? gnt_q : '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      b_q     <= 1'b0;
      a_q     <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      b_q     <= b_d;
      a_q     <= a_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      txn_q   <= txn_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign start   = start_q;
  assign b       = b_q;
  assign a       = a_q;
  assign stop    = stop_q;
  assign busy    = busy_q;
  assign txn_cnt = txn_q;

endmodule

// File: tb/tb_start_stop_seq_arbiter.sv
// Bench for start_stop_seq_arbiter: three parameter sets checked
// against a timeline model of each transaction.
module tb_start_stop_seq_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] gnt_w   [3];
  logic [3:0] done_w  [3];
  logic       start_w [3];
  logic       b_w     [3];
  logic       a_w     [3];
  logic       stop_w  [3];
  logic       busy_w  [3];
  logic [3:0] txn_w   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    start_stop_seq_arbiter #(
      .NREQ     (4),
      .A_DLY    (g == 1 ? 3 : 1),
      .STOP_GAP (g == 0 ? 2 : (g == 1 ? 3 : 4)),
      .CNT_W    (4)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt_w[g]),
      .done    (done_w[g]),
      .start   (start_w[g]),
      .b       (b_w[g]),
      .a       (a_w[g]),
      .stop    (stop_w[g]),
      .busy    (busy_w[g]),
      .txn_cnt (txn_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  bit         m_in  [3];
  int         m_off [3];
  int         m_g   [3];
  int         m_ptr [3];
  int         m_txn [3];
  logic [3:0] prev_s[3];

  function automatic int a_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic int s_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_in[k]   = 1'b0;
      m_off[k]  = 0;
      m_g[k]    = 0;
      m_ptr[k]  = 0;
      m_txn[k]  = 0;
      prev_s[k] = '0;
    end
  endtask

  // expected outputs from the offset within the current transaction
  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      bit         act;
      int         o;
      logic [3:0] eg;
      logic [3:0] cur;
      bit         e_stop;
      act    = m_in[k];
      o      = m_off[k];
      eg     = act ? 4'(1 << m_g[k]) : 4'b0;
      e_stop = act && (o == 1 + s_of(k));
      check($sformatf("d%0d_gnt", k),
            32'(gnt_w[k]), 32'(eg));
      check($sformatf("d%0d_done", k),
            32'(done_w[k]), 32'(e_stop ? eg : 4'b0));
      check($sformatf("d%0d_start", k),
            32'(start_w[k]), 32'(act && o == 0));
      check($sformatf("d%0d_b", k),
            32'(b_w[k]), 32'(act && o == 1));
      check($sformatf("d%0d_a", k),
            32'(a_w[k]), 32'(act && o == 1 + a_of(k)));
      check($sformatf("d%0d_stop", k),
            32'(stop_w[k]), 32'(e_stop));
      check($sformatf("d%0d_busy", k),
            32'(busy_w[k]), 32'(act));
      check($sformatf("d%0d_txn", k),
            32'(txn_w[k]), 32'(m_txn[k] % 16));
      check($sformatf("d%0d_onehot0", k),
            32'($onehot0(gnt_w[k])), 32'(1));
      cur = {start_w[k], b_w[k], a_w[k], stop_w[k]};
      check($sformatf("d%0d_consec", k),
            32'(cur & prev_s[k]), 32'(0));
      prev_s[k] = cur;
    end
  endtask

  // advance the model by one clock with request vector r
  task automatic model_step(input logic [3:0] r);
    for (int k = 0; k < 3; k++) begin
      if (m_in[k]) begin
        if (m_off[k] == 1 + s_of(k)) begin
          m_in[k]  = 1'b0;
          m_ptr[k] = (m_g[k] + 1) % 4;
          m_txn[k] = m_txn[k] + 1;
        end else begin
          m_off[k] = m_off[k] + 1;
        end
      end else if (r != 4'b0) begin
        for (int j = 0; j < 4; j++) begin
          int c;
          c = (m_ptr[k] + j) % 4;
          if (r[2'(c)]) begin
            m_g[k] = c;
            break;
          end
        end
        m_in[k]  = 1'b1;
        m_off[k] = 0;
      end
    end
  endtask

  task automatic cycle(input logic [3:0] r);
    compare_all();
    req = r;
    model_step(r);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s%0d", tag, k),
            32'({gnt_w[k], done_w[k], start_w[k],
                 b_w[k], a_w[k], stop_w[k],
                 busy_w[k], txn_w[k]}),
            32'(0));
    end
  endtask

  initial begin
    int w;
    n_chk  = 0;
    n_pass = 0;
    req    = 4'b0;
    rst_n  = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(4'b0001);
    for (int i = 0; i < 8; i++) cycle(4'b0000);

    for (int i = 0; i < 40; i++) cycle(4'b1111);
    for (int i = 0; i < 8; i++) cycle(4'b0000);

    for (int i = 0; i < 30; i++) cycle(4'b1001);
    for (int i = 0; i < 8; i++) cycle(4'b0000);

    w = 0;
    while (!(m_in[0] && m_off[0] == 2) && w < 20) begin
      cycle(4'b0001);
      w++;
    end
    check("rst_reach", 32'(w < 20), 32'(1));
    #1 rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    req = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle(4'b0010);

    for (int i = 0; i < 1000; i++) begin
      cycle(4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
